// File: rtl/arb_muxn.sv
// N-way WIDTH-bit selector with direct or round-robin grant, valid/ready on every
// input and a single registered output stage that runs at one word per cycle.
module arb_muxn #(
  parameter int WIDTH = 32,
  parameter int N     = 12,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel
);

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SELW-1:0]  sel_p1;
  logic [SELW-1:0]  rr_ptr;

  logic             accept_p0;
  logic             grant_vld_p0;
  logic [SELW-1:0]  grant_p0;
  logic [WIDTH-1:0] data_p0;
  logic [N-1:0]     upper_p0;
  logic             upper_hit_p0;
  logic [SELW-1:0]  upper_idx_p0;
  logic [SELW-1:0]  low_idx_p0;

  // Stage p0: grant decision and data selection
  assign accept_p0 = !vld_p1 || out_ready;

  always_comb begin
    upper_p0     = '0;
    upper_idx_p0 = '0;
    low_idx_p0   = '0;
    // The search from rr_ptr upward wins; the lowest requester overall covers the wrap.
    for (int j = N - 1; j >= 0; j--) begin
      upper_p0[j] = in_valid[j] && (SELW'(j) >= rr_ptr);
      if (upper_p0[j]) upper_idx_p0 = SELW'(j);
      if (in_valid[j]) low_idx_p0 = SELW'(j);
    end
    upper_hit_p0 = |upper_p0;
  end

  always_comb begin
    grant_vld_p0 = 1'b0;
    grant_p0     = '0;
    if (mode) begin
      grant_vld_p0 = |in_valid;
      grant_p0     = upper_hit_p0 ? upper_idx_p0 : low_idx_p0;
    end else if (int'(sel) < N) begin
      grant_vld_p0 = in_valid[sel];
      grant_p0     = sel;
    end
  end

  always_comb begin
    data_p0 = '0;
    for (int j = 0; j < N; j++) begin
      if (SELW'(j) == grant_p0) data_p0 = in_data[j*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    if (!reset && accept_p0 && grant_vld_p0) begin
      for (int j = 0; j < N; j++) begin
        in_ready[j] = (SELW'(j) == grant_p0);
      end
    end
  end

  // Stage p1: output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      rr_ptr  <= '0;
    end else if (accept_p0) begin
      if (grant_vld_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= data_p0;
        sel_p1  <= grant_p0;
        if (mode) rr_ptr <= (grant_p0 == SELW'(N - 1)) ? '0 : grant_p0 + 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;

endmodule

// File: tb/tb_arb_muxn.sv
// Bench for arb_muxn: directed scenarios plus randomized traffic, all checked
// against a queue-free behavioural model of the selector.
module tb_arb_muxn;
  localparam int WIDTH = 32;
  localparam int N     = 12;
  localparam int SELW  = $clog2(N);

  logic               clk = 1'b0;
  logic               reset;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit               m_vld  = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  int               m_sel  = 0;
  int               m_ptr  = 0;

  always #5 clk = ~clk;

  arb_muxn #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  function automatic int exp_grant();
    if (reset) return -1;
    if (m_vld && !out_ready) return -1;
    if (!mode) begin
      if (int'(sel) >= N) return -1;
      return in_valid[sel] ? int'(sel) : -1;
    end
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] r;
    g = exp_grant();
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    int g;
    g = exp_grant();
    if (reset) begin
      m_vld = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (!m_vld || out_ready) begin
      if (g >= 0) begin
        m_vld  = 1'b1;
        m_data = in_data[g*WIDTH +: WIDTH];
        m_sel  = g;
        if (mode) m_ptr = (g + 1) % N;
      end else begin
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic md, input int s,
                       input logic [N-1:0] v, input logic ordy);
    @(negedge clk);
    reset     = r;
    mode      = md;
    sel       = SELW'(s);
    in_valid  = v;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic fill_counting();
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(32'h100 + i);
  endtask

  task automatic test_reset();
    fill_counting();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 0, '1, 1'b1);
      checks++;
      if (in_ready !== '0) begin
        failures++; $display("FAIL reset_ready got=%h exp=0", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
        failures++;
        $display("FAIL reset_out got v=%b d=%h s=%0d exp v=0 d=0 s=0", out_valid, out_data, out_sel);
      end
    end
  endtask

  task automatic test_direct();
    fill_counting();
    drive(1'b0, 1'b0, 5, '1, 1'b1);
    checks++;
    if (in_ready !== 12'h020) begin
      failures++; $display("FAIL direct_ready got=%h exp=020", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h105 || out_sel !== 4'd5) begin
      failures++;
      $display("FAIL direct_out got v=%b d=%h s=%0d exp v=1 d=105 s=5", out_valid, out_data, out_sel);
    end
    drive(1'b0, 1'b0, 12, '1, 1'b1);
    checks++;
    if (in_ready !== '0) begin
      failures++; $display("FAIL direct_oob_ready got=%h exp=0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h105 || out_sel !== 4'd5) begin
      failures++;
      $display("FAIL direct_oob_out got v=%b d=%h s=%0d exp v=0 d=105 s=5", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_rr_fairness();
    int pair [4] = '{3, 9, 3, 9};
    fill_counting();
    for (int c = 0; c < 14; c++) begin
      drive(1'b0, 1'b1, 0, '1, 1'b1);
      checks++;
      if (in_ready !== exp_ready()) begin
        failures++; $display("FAIL rr_ready cyc=%0d got=%h exp=%h", c, in_ready, exp_ready());
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_sel) != c % N || out_data !== WIDTH'(32'h100 + c % N)) begin
        failures++;
        $display("FAIL rr_seq cyc=%0d got s=%0d d=%h exp s=%0d", c, out_sel, out_data, c % N);
      end
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b1, 0, 12'h208, 1'b1);
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_sel) != pair[c]) begin
        failures++; $display("FAIL rr_pair cyc=%0d got s=%0d exp s=%0d", c, out_sel, pair[c]);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_s [3] = '{11, 0, 11};
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 0, 12'h801, 1'b1);
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_sel) != exp_s[c] || int'(out_sel) != m_sel) begin
        failures++; $display("FAIL wrap cyc=%0d got s=%0d exp s=%0d", c, out_sel, exp_s[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    fill_counting();
    drive(1'b0, 1'b0, 7, '1, 1'b1);
    tick();
    checks++;
    if (out_data !== 32'h107 || out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_load got v=%b d=%h exp v=1 d=107", out_valid, out_data);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 0, '1, 1'b0);
      checks++;
      if (in_ready !== '0) begin
        failures++; $display("FAIL bp_ready cyc=%0d got=%h exp=0", c, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h107 || out_sel !== 4'd7) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h s=%0d exp v=1 d=107 s=7", c, out_valid, out_data, out_sel);
      end
    end
    drive(1'b0, 1'b1, 0, '1, 1'b1);
    checks++;
    if (in_ready !== 12'h001) begin
      failures++; $display("FAIL bp_release_ready got=%h exp=001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h100 || out_sel !== 4'd0) begin
      failures++; $display("FAIL bp_release got v=%b d=%h exp v=1 d=100", out_valid, out_data);
    end
  endtask

  task automatic test_mode_switch();
    int exp_s [6] = '{0, 1, 7, 7, 7, 2};
    fill_counting();
    drive(1'b1, 1'b0, 0, '0, 1'b1);
    tick();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, (c < 2 || c == 5), 7, '1, 1'b1);
      tick();
      checks++;
      if (out_valid !== 1'b1 || int'(out_sel) != exp_s[c]) begin
        failures++; $display("FAIL mode_switch cyc=%0d got s=%0d exp s=%0d", c, out_sel, exp_s[c]);
      end
    end
    drive(1'b0, 1'b1, 0, '0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 0, '1, 1'b0);
    checks++;
    if (in_ready !== '0) begin
      failures++; $display("FAIL mid_reset_ready got=%h exp=0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
      failures++; $display("FAIL mid_reset got v=%b d=%h s=%0d exp v=0 d=0 s=0", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    for (int c = 0; c < 400; c++) begin
      v = N'($urandom) & N'($urandom);
      drive(($urandom_range(0, 49) == 0), 1'($urandom), int'($urandom_range(0, 15)), v,
            ($urandom_range(0, 3) != 0));
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
      checks++;
      if (in_ready !== exp_ready()) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%h exp=%h", c, in_ready, exp_ready());
      end
      tick();
      checks++;
      if (out_valid !== m_vld || out_data !== m_data || int'(out_sel) != m_sel) begin
        failures++;
        $display("FAIL rand_out cyc=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
                 c, out_valid, out_data, out_sel, m_vld, m_data, m_sel);
      end
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_direct();
    test_rr_fairness();
    test_wrap();
    test_backpressure();
    test_mode_switch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
